// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding imem request, stall buffer and redirect handling.
// Optional performance counters are enabled with the IF_PERF_CNT_EN macro.
module if_stage #(
    parameter int unsigned        D_WIDTH  = 32,
    parameter int unsigned        RF_SIZE  = 5,
    parameter logic [D_WIDTH-1:0] RESET_PC = D_WIDTH'(32'h0000_0000)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               redirect_valid,
    input  logic [D_WIDTH-1:0] redirect_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [D_WIDTH-1:0] imem_addr,
    input  logic               imem_rsp_valid,
    input  logic [D_WIDTH-1:0] imem_rsp_data,
    output logic [D_WIDTH-1:0] instr,
    output logic [RF_SIZE-1:0] rs1,
    output logic [RF_SIZE-1:0] rs2,
    output logic [RF_SIZE-1:0] rd,
    output logic [6:0]         opcode,
    output logic [2:0]         funct3,
    output logic [6:0]         funct7,
    output logic [D_WIDTH-1:0] pc_id,
    output logic               valid_id
`ifdef IF_PERF_CNT_EN
    ,output logic [31:0]       fetch_cnt
    ,output logic [31:0]       stall_cnt
`endif
);

    localparam logic [D_WIDTH-1:0] NOP = D_WIDTH'(32'h0000_0013);

    typedef enum logic [1:0] {StReq, StWait, StHold, StDrop} state_e;

    state_e             r_state, w_state_d;
    logic [D_WIDTH-1:0] r_pc, w_pc_d;
    logic [D_WIDTH-1:0] r_inflight_pc, w_inflight_d;
    logic [D_WIDTH-1:0] r_buf, w_buf_d;
    logic [D_WIDTH-1:0] r_instr;
    logic [D_WIDTH-1:0] r_pc_id;
    logic               r_valid_id;
    logic               w_load;
    logic [D_WIDTH-1:0] w_load_data;

    always_comb begin
        w_state_d    = r_state;
        w_pc_d       = r_pc;
        w_inflight_d = r_inflight_pc;
        w_buf_d      = r_buf;
        w_load       = 1'b0;
        w_load_data  = r_buf;
        unique case (r_state)
            StReq: begin
                if (imem_req_ready) begin
                    w_inflight_d = r_pc;
                    w_state_d    = redirect_valid ? StDrop : StWait;
                end
            end
            StWait: begin
                if (imem_rsp_valid) begin
                    if (redirect_valid) begin
                        w_state_d = StReq;
                    end else if (en) begin
                        w_load      = 1'b1;
                        w_load_data = imem_rsp_data;
                        w_pc_d      = r_inflight_pc + D_WIDTH'(4);
                        w_state_d   = StReq;
                    end else begin
                        w_buf_d   = imem_rsp_data;
                        w_state_d = StHold;
                    end
                end else if (redirect_valid) begin
                    w_state_d = StDrop;
                end
            end
            StHold: begin
                if (redirect_valid) begin
                    w_buf_d   = '0;
                    w_state_d = StReq;
                end else if (en) begin
                    w_load      = 1'b1;
                    w_load_data = r_buf;
                    w_pc_d      = r_inflight_pc + D_WIDTH'(4);
                    w_state_d   = StReq;
                end
            end
            StDrop: begin
                // A dropped response always leaves DROP, even if a new redirect arrives with it.
                if (imem_rsp_valid) begin
                    w_state_d = StReq;
                end
            end
            default: w_state_d = StReq;
        endcase
        if (redirect_valid) begin
            w_pc_d = redirect_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= StReq;
            r_pc          <= RESET_PC;
            r_inflight_pc <= '0;
            r_buf         <= '0;
        end else begin
            r_state       <= w_state_d;
            r_pc          <= w_pc_d;
            r_inflight_pc <= w_inflight_d;
            r_buf         <= w_buf_d;
        end
    end

    // Redirect forces a bubble even when ID is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr    <= NOP;
            r_pc_id    <= '0;
            r_valid_id <= 1'b0;
        end else if (redirect_valid) begin
            r_instr    <= NOP;
            r_valid_id <= 1'b0;
        end else if (w_load) begin
            r_instr    <= w_load_data;
            r_pc_id    <= r_inflight_pc;
            r_valid_id <= 1'b1;
        end else if (en) begin
            r_instr    <= NOP;
            r_valid_id <= 1'b0;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_load) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (!en) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign fetch_cnt = r_fetch_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

    assign imem_req_valid = (r_state == StReq);
    assign imem_addr      = r_pc;
    assign instr          = r_instr;
    assign opcode         = r_instr[6:0];
    assign rd             = RF_SIZE'(r_instr[11:7]);
    assign funct3         = r_instr[14:12];
    assign rs1            = RF_SIZE'(r_instr[19:15]);
    assign rs2            = RF_SIZE'(r_instr[24:20]);
    assign funct7         = r_instr[31:25];
    assign pc_id          = r_pc_id;
    assign valid_id       = r_valid_id;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: imem model, expected deliveries queued at request acceptance.
// A second instance starts at 0xFFFF_FFFC to exercise PC wrap.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] instr;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [31:0] pc_id;
    logic        valid_id;

    logic        w_en, w_redirect_valid, w_req_valid, w_req_ready, w_rsp_valid, w_valid_id;
    logic [31:0] w_redirect_pc, w_addr, w_rsp_data, w_instr, w_pc_id;
    logic [4:0]  w_rs1, w_rs2, w_rd;
    logic [6:0]  w_opcode, w_funct7;
    logic [2:0]  w_funct3;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt, stall_cnt, w_fetch_cnt, w_stall_cnt;
`endif

    if_stage dut (
        .clk(clk), .rst(rst), .en(en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr(instr), .rs1(rs1), .rs2(rs2), .rd(rd),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .pc_id(pc_id), .valid_id(valid_id)
`ifdef IF_PERF_CNT_EN
        ,.fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
`endif
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(rst), .en(w_en),
        .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_addr(w_addr),
        .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
        .instr(w_instr), .rs1(w_rs1), .rs2(w_rs2), .rd(w_rd),
        .opcode(w_opcode), .funct3(w_funct3), .funct7(w_funct7),
        .pc_id(w_pc_id), .valid_id(w_valid_id)
`ifdef IF_PERF_CNT_EN
        ,.fetch_cnt(w_fetch_cnt), .stall_cnt(w_stall_cnt)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int n_dlv    = 0;
    int n_stall  = 0;
    int w_n_dlv  = 0;
    bit hold_rsp = 0;

    logic [31:0] exp_pc_q[$], exp_ins_q[$], pend_q[$], w_pend_q[$];
    logic [31:0] addr_log[$], pcid_log[$], w_addr_log[$], w_pcid_log[$];
    int          acc_cyc_q[$], dlv_cyc_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'h0050_0093 ^ (a << 5);
    endfunction

    // One clock: sample pre-edge handshakes, advance, update imem models, score ID outputs.
    task automatic step();
        bit          acc, rsp_t, en_s, red_s, rst_s, w_acc, w_rsp_t;
        logic [31:0] a, w_a, h_instr, h_pc, e_pc, e_ins;
        logic        h_v;
        acc     = imem_req_valid && imem_req_ready && !rst;
        a       = imem_addr;
        rsp_t   = imem_rsp_valid;
        en_s    = en;
        red_s   = redirect_valid;
        rst_s   = rst;
        h_instr = instr;
        h_pc    = pc_id;
        h_v     = valid_id;
        w_acc   = w_req_valid && w_req_ready && !rst;
        w_a     = w_addr;
        w_rsp_t = w_rsp_valid;
        @(posedge clk);
        #1;
        if (!rst_s && !en_s) n_stall++;
        if (rsp_t) imem_rsp_valid = 1'b0;
        if (acc) begin
            pend_q.push_back(a);
            addr_log.push_back(a);
            acc_cyc_q.push_back(cyc);
            exp_pc_q.push_back(a);
            exp_ins_q.push_back(mem(a));
        end
        cyc++;
        if (red_s) begin
            exp_pc_q.delete();
            exp_ins_q.delete();
        end
        if (!hold_rsp && pend_q.size() > 0 && !imem_rsp_valid) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem(pend_q.pop_front());
        end
        if (rst_s) begin
            // reset state is checked directly by the test sequence
        end else if (red_s) begin
            check("redir_valid", 32'(valid_id), 32'd0);
            check("redir_instr", instr, 32'h13);
        end else if (en_s) begin
            if (valid_id) begin
                n_dlv++;
                pcid_log.push_back(pc_id);
                dlv_cyc_q.push_back(cyc);
                if (exp_pc_q.size() == 0) begin
                    check("sb_unexpected_pc", pc_id, 32'hxxxx_xxxx);
                end else begin
                    e_pc  = exp_pc_q.pop_front();
                    e_ins = exp_ins_q.pop_front();
                    check("sb_pc_id", pc_id, e_pc);
                    check("sb_instr", instr, e_ins);
                    check("sb_fields", {funct7, rs2, rs1, funct3, rd, opcode}, e_ins);
                end
            end else begin
                check("bubble_instr", instr, 32'h13);
            end
        end else begin
            check("hold_instr", instr, h_instr);
            check("hold_pc_id", pc_id, h_pc);
            check("hold_valid", 32'(valid_id), 32'(h_v));
        end

        if (w_rsp_t) w_rsp_valid = 1'b0;
        if (w_acc) begin
            w_pend_q.push_back(w_a);
            w_addr_log.push_back(w_a);
        end
        if (w_pend_q.size() > 0 && !w_rsp_valid) begin
            w_rsp_valid = 1'b1;
            w_rsp_data  = mem(w_pend_q.pop_front());
        end
        if (!rst_s && w_valid_id) begin
            w_n_dlv++;
            w_pcid_log.push_back(w_pc_id);
            check("w_fields", {w_funct7, w_rs2, w_rs1, w_funct3, w_rd, w_opcode}, w_instr);
            check("w_instr", w_instr, mem(w_pc_id));
        end
    endtask

    task automatic clear_logs();
        addr_log.delete();
        pcid_log.delete();
        acc_cyc_q.delete();
        dlv_cyc_q.delete();
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        w_en = 1'b1; w_redirect_valid = 1'b0; w_redirect_pc = '0; w_req_ready = 1'b1;
        w_rsp_valid = 1'b0; w_rsp_data = '0;
        step();
        step();
        check("rst_instr", instr, 32'h13);
        check("rst_fields", {funct7, rs2, rs1, funct3, rd, opcode}, 32'h13);
        check("rst_pc_id", pc_id, 32'd0);
        check("rst_valid", 32'(valid_id), 32'd0);
        check("rst_req_valid", 32'(imem_req_valid), 32'd1);
        check("rst_addr", imem_addr, 32'd0);
        rst = 1'b0;

        // Three back-to-back fetches with immediate responses.
        clear_logs();
        imem_req_ready = 1'b1;
        repeat (6) step();
        imem_req_ready = 1'b0;
        step();
        check("seq_n_addr", 32'(addr_log.size()), 32'd3);
        check("seq_n_pcid", 32'(pcid_log.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < addr_log.size()) check("seq_addr", addr_log[i], 32'(4 * i));
            if (i < pcid_log.size()) check("seq_pc_id", pcid_log[i], 32'(4 * i));
        end
        if (acc_cyc_q.size() > 0 && dlv_cyc_q.size() > 1) begin
            check("latency", 32'(dlv_cyc_q[0] - acc_cyc_q[0]), 32'd2);
            check("throughput", 32'(dlv_cyc_q[1] - dlv_cyc_q[0]), 32'd2);
        end

        // Response arrives while ID stalled for 5 cycles.
        clear_logs();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        en = 1'b0;
        repeat (5) begin
            step();
            check("hold_no_req", 32'(imem_req_valid), 32'd0);
        end
        en = 1'b1;
        step();
        check("hold_dlv_valid", 32'(valid_id), 32'd1);
        check("hold_dlv_pc", pc_id, 32'd12);
        check("hold_no_new_acc", 32'(addr_log.size()), 32'd1);

        // Redirect in WAIT, response lands in the following cycle.
        clear_logs();
        hold_rsp = 1'b1;
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        hold_rsp = 1'b0;
        step();
        redirect_valid = 1'b0;
        check("drop_no_req", 32'(imem_req_valid), 32'd0);
        step();
        check("drop_req_valid", 32'(imem_req_valid), 32'd1);
        check("drop_next_addr", imem_addr, 32'h100);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        step();
        check("redir_dlv_pc", pc_id, 32'h100);

        // Redirect coincident with handshake at 0xFFFF_FFFC.
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        check("redir_req_addr", imem_addr, 32'hFFFF_FFFC);
        imem_req_ready = 1'b1;
        redirect_pc = 32'h200;
        step();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        check("hs_redir_drop", 32'(imem_req_valid), 32'd0);
        step();
        step();
        check("hs_redir_req", 32'(imem_req_valid), 32'd1);
        check("hs_redir_addr", imem_addr, 32'h200);

        // Redirect in WAIT together with the response: straight back to REQ.
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h300;
        step();
        redirect_valid = 1'b0;
        check("wait_rsp_redir_req", 32'(imem_req_valid), 32'd1);
        check("wait_rsp_redir_addr", imem_addr, 32'h300);

        // Redirect in HOLD discards the buffered instruction.
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        en = 1'b0;
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h400;
        step();
        redirect_valid = 1'b0;
        en = 1'b1;
        check("hold_redir_req", 32'(imem_req_valid), 32'd1);
        check("hold_redir_addr", imem_addr, 32'h400);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        step();
        check("hold_redir_dlv_pc", pc_id, 32'h400);
        check("hold_redir_dlv_v", 32'(valid_id), 32'd1);
        step();

        check("sb_left", 32'(exp_pc_q.size()), 32'd0);
        check("w_n_addr", 32'(w_addr_log.size() >= 2), 32'd1);
        check("w_n_pcid", 32'(w_pcid_log.size() >= 2), 32'd1);
        if (w_addr_log.size() >= 2 && w_pcid_log.size() >= 2) begin
            check("w_addr0", w_addr_log[0], 32'hFFFF_FFFC);
            check("w_addr1_wrap", w_addr_log[1], 32'h0);
            check("w_pcid0", w_pcid_log[0], 32'hFFFF_FFFC);
            check("w_pcid1_wrap", w_pcid_log[1], 32'h0);
        end
`ifdef IF_PERF_CNT_EN
        check("fetch_cnt", fetch_cnt, 32'(n_dlv));
        check("stall_cnt", stall_cnt, 32'(n_stall));
        check("w_fetch_cnt", w_fetch_cnt, 32'(w_n_dlv));
        check("w_stall_cnt", w_stall_cnt, 32'd0);
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
